regfile_seed_writer: RTL and testbench

//  Walks a table of 32-bit seed values and writes them, one per slot, into the register

---
 rtl/regfile_seed_writer.sv | 175 +++++++++++++++++
 tb/tb_regfile_seed_writer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_seed_writer.sv
// Seeds consecutive regfile registers from a synchronous table ROM and muxes the seeding
// writes with the processor write-back port. Optional read-back compare: READBACK_CHECK_EN.
module regfile_seed_writer #(
    parameter int NUM_ENTRIES = 15,
    parameter int FIRST_REG   = 1,
    parameter int GAP         = 8
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        start,
    output logic [4:0]  tbl_addr,
    input  logic [31:0] tbl_data,
    input  logic        proc_ctrl_writeEnable,
    input  logic [4:0]  proc_ctrl_writeReg,
    input  logic [31:0] proc_data_writeReg,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic        busy,
    output logic        done,
    output logic [7:0]  collisions
`ifdef READBACK_CHECK_EN
    ,
    output logic [4:0]  ctrl_readRegB,
    input  logic [31:0] data_readRegB,
    output logic [7:0]  mismatches
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WRITE,
        WAIT,
        DONE
    } state_t;

    state_t      state_q;
    logic [4:0]  idx_q;
    logic [4:0]  tblAddr_q;
    logic [15:0] gapCnt_q;
    logic        busy_q;
    logic        done_q;
    logic [7:0]  collisions_q;
    logic [7:0]  collisions_d;

    logic [4:0]  slotReg;
    logic        slotSkip;
    logic        seedWrite;

    // Destination wraps modulo 32; a wrapped address of r0 turns the slot into a no-op.
    assign slotReg      = 5'(FIRST_REG) + idx_q;
    assign slotSkip     = (slotReg == 5'd0);
    assign seedWrite    = (state_q == WRITE) && ctrl_reset && !slotSkip && !proc_ctrl_writeEnable;
    assign collisions_d = (collisions_q == 8'hFF) ? collisions_q : collisions_q + 8'd1;

`ifdef READBACK_CHECK_EN
    logic [4:0]  lastReg_q;
    logic [31:0] lastData_q;
    logic        checkPending_q;
    logic [7:0]  mismatches_q;
    logic [7:0]  mismatches_d;

    assign mismatches_d  = (mismatches_q == 8'hFF) ? mismatches_q : mismatches_q + 8'd1;
    assign ctrl_readRegB = (state_q == WAIT) ? lastReg_q : 5'd0;
    assign mismatches    = mismatches_q;
`else
    logic lastSlot;

    assign lastSlot = (idx_q == 5'(NUM_ENTRIES - 1));
`endif

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            state_q      <= IDLE;
            idx_q        <= 5'd0;
            tblAddr_q    <= 5'd0;
            gapCnt_q     <= 16'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            collisions_q <= 8'd0;
`ifdef READBACK_CHECK_EN
            lastReg_q      <= 5'd0;
            lastData_q     <= 32'd0;
            checkPending_q <= 1'b0;
            mismatches_q   <= 8'd0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q   <= FETCH;
                        idx_q     <= 5'd0;
                        tblAddr_q <= 5'd0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                FETCH: begin
                    state_q <= WRITE;
                end
                WRITE: begin
                    // tbl_addr is held through retries, so tbl_data stays valid until the write lands.
                    if (!slotSkip && proc_ctrl_writeEnable) begin
                        collisions_q <= collisions_d;
                    end else begin
                        idx_q    <= idx_q + 5'd1;
                        gapCnt_q <= 16'(GAP - 3);
`ifdef READBACK_CHECK_EN
                        lastReg_q      <= slotSkip ? 5'd0 : slotReg;
                        lastData_q     <= tbl_data;
                        checkPending_q <= !slotSkip;
                        state_q        <= WAIT;
`else
                        if (lastSlot) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
`endif
                    end
                end
                WAIT: begin
                    if (gapCnt_q == 16'd0) begin
`ifdef READBACK_CHECK_EN
                        if (checkPending_q && (data_readRegB != lastData_q)) begin
                            mismatches_q <= mismatches_d;
                        end
                        if (idx_q == 5'(NUM_ENTRIES)) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= FETCH;
                            tblAddr_q <= idx_q;
                        end
`else
                        state_q   <= FETCH;
                        tblAddr_q <= idx_q;
`endif
                    end else begin
                        gapCnt_q <= gapCnt_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The processor always wins the regfile port; the seeder only drives it when WRITE is unopposed.
    always_comb begin
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'd0;
        if (proc_ctrl_writeEnable) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = proc_ctrl_writeReg;
            data_writeReg    = proc_data_writeReg;
        end else if (seedWrite) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = slotReg;
            data_writeReg    = tbl_data;
        end
    end

    assign tbl_addr   = tblAddr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign collisions = collisions_q;

endmodule

// File: tb/tb_regfile_seed_writer.sv
// Directed bench for regfile_seed_writer: table ROM and regfile models around a default
// instance and a wrap-around instance (FIRST_REG=30, NUM_ENTRIES=4).
module tb_regfile_seed_writer;

    localparam int GAP = 8;
`ifdef READBACK_CHECK_EN
    localparam int DONE_LAT  = 15 * GAP;
    localparam int DONE_LAT2 = 4 * GAP;
`else
    localparam int DONE_LAT  = 14 * GAP + 2;
    localparam int DONE_LAT2 = 3 * GAP + 2;
`endif

    logic        clock = 1'b0;
    logic        ctrlReset;
    logic        start;
    logic        start2;
    logic [4:0]  tblAddr;
    logic [31:0] tblData;
    logic        procWe;
    logic [4:0]  procReg;
    logic [31:0] procData;
    logic        wrEn;
    logic [4:0]  wrReg;
    logic [31:0] wrData;
    logic        busy;
    logic        done;
    logic [7:0]  collisions;

    logic [4:0]  tblAddr2;
    logic [31:0] tblData2;
    logic        wrEn2;
    logic [4:0]  wrReg2;
    logic [31:0] wrData2;
    logic        busy2;
    logic        done2;
    logic [7:0]  collisions2;

    logic [31:0] rom  [0:31];
    logic [31:0] rom2 [0:31];
    logic [31:0] regs [0:31];
    logic [31:0] regs2 [0:31];
    logic        clearReq;
    int          cyc = 0;
    int          pulses2 = 0;
    int          wrCyc[$];
    logic [4:0]  wrRegLog[$];

    int vectors = 0;
    int miscompares = 0;
    int startCyc = 0;
    int doneAt;
    int viol;

`ifdef READBACK_CHECK_EN
    logic [4:0]  readRegB;
    logic [31:0] readData;
    logic [7:0]  mismatches;
    logic [4:0]  readRegB2;
    logic [31:0] readData2;
    logic [7:0]  mismatches2;
    logic        corruptR9;

    assign readData  = regs[readRegB] ^ ((corruptR9 && readRegB == 5'd9) ? 32'h1 : 32'h0);
    assign readData2 = regs2[readRegB2];
`endif

    always #5 clock = ~clock;

    regfile_seed_writer dut (
        .clock                 (clock),
        .ctrl_reset            (ctrlReset),
        .start                 (start),
        .tbl_addr              (tblAddr),
        .tbl_data              (tblData),
        .proc_ctrl_writeEnable (procWe),
        .proc_ctrl_writeReg    (procReg),
        .proc_data_writeReg    (procData),
        .ctrl_writeEnable      (wrEn),
        .ctrl_writeReg         (wrReg),
        .data_writeReg         (wrData),
        .busy                  (busy),
        .done                  (done),
        .collisions            (collisions)
`ifdef READBACK_CHECK_EN
        ,
        .ctrl_readRegB         (readRegB),
        .data_readRegB         (readData),
        .mismatches            (mismatches)
`endif
    );

    regfile_seed_writer #(.NUM_ENTRIES(4), .FIRST_REG(30), .GAP(GAP)) dut2 (
        .clock                 (clock),
        .ctrl_reset            (ctrlReset),
        .start                 (start2),
        .tbl_addr              (tblAddr2),
        .tbl_data              (tblData2),
        .proc_ctrl_writeEnable (1'b0),
        .proc_ctrl_writeReg    (5'd0),
        .proc_data_writeReg    (32'd0),
        .ctrl_writeEnable      (wrEn2),
        .ctrl_writeReg         (wrReg2),
        .data_writeReg         (wrData2),
        .busy                  (busy2),
        .done                  (done2),
        .collisions            (collisions2)
`ifdef READBACK_CHECK_EN
        ,
        .ctrl_readRegB         (readRegB2),
        .data_readRegB         (readData2),
        .mismatches            (mismatches2)
`endif
    );

    // Synchronous ROMs, regfile models and write log; r0 is hardwired to its sentinel.
    always @(posedge clock) begin
        tblData  <= rom[tblAddr];
        tblData2 <= rom2[tblAddr2];
        if (clearReq) begin
            for (int i = 0; i < 32; i++) begin
                regs[i]  <= 32'hDEAD0000 | 32'(i);
                regs2[i] <= 32'hDEAD0000 | 32'(i);
            end
            wrCyc.delete();
            wrRegLog.delete();
            pulses2 <= 0;
        end
        if (wrEn) begin
            if (wrReg != 5'd0) regs[wrReg] <= wrData;
            wrCyc.push_back(cyc);
            wrRegLog.push_back(wrReg);
        end
        if (wrEn2) begin
            if (wrReg2 != 5'd0) regs2[wrReg2] <= wrData2;
            pulses2 <= pulses2 + 1;
        end
        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s1, input logic s2);
        startCyc = cyc;
        start    = s1;
        start2   = s2;
        @(negedge clock);
        start    = 1'b0;
        start2   = 1'b0;
        clearReq = 1'b0;
    endtask

    task automatic waitDone(input bit sel, output int lat);
        lat = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if ((sel ? done2 : done) === 1'b1) begin
                lat = cyc - 1 - startCyc;
                break;
            end
        end
    endtask

    task automatic checkSpacing(input string tag);
        viol = 0;
        for (int i = 1; i < wrCyc.size(); i++) begin
            if (wrCyc[i] - wrCyc[i-1] != GAP) viol++;
        end
        checkOutput(tag, viol, 0);
    endtask

    task automatic checkTable(input string tag);
        for (int i = 1; i <= 15; i++) begin
            checkOutput($sformatf("%s_r%0d", tag, i), regs[i], rom[i-1]);
        end
        checkOutput({tag, "_r16"}, regs[16], 32'hDEAD0010);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rom[0] = 32'd65535;       rom[1] = 32'd2147450880;  rom[2] = 32'd2147483647;
        rom[3] = 32'd0;           rom[4] = 32'd0;           rom[5] = 32'd0;
        rom[6] = 32'd1;           rom[7] = 32'd2;           rom[8] = 32'd3;
        rom[9] = 32'd0;           rom[10] = 32'd0;          rom[11] = 32'd0;
        rom[12] = 32'h80000000;   rom[13] = 32'hFFFFFFFF;   rom[14] = 32'd0;
        for (int i = 15; i < 32; i++) rom[i] = 32'h5EED0000 | 32'(i);
        for (int i = 0; i < 32; i++) rom2[i] = 32'hA5A50000 + 32'(i);

        ctrlReset = 1'b0;
        start     = 1'b0;
        start2    = 1'b0;
        procWe    = 1'b0;
        procReg   = 5'd0;
        procData  = 32'd0;
        clearReq  = 1'b1;
`ifdef READBACK_CHECK_EN
        corruptR9 = 1'b1;
`endif
        repeat (3) @(negedge clock);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_collisions", collisions, 8'd0);
        checkOutput("rst_tbl_addr", tblAddr, 5'd0);
        checkOutput("rst_we", wrEn, 1'b0);
        checkOutput("rst_busy2", busy2, 1'b0);
        ctrlReset = 1'b1;
        clearReq  = 1'b0;
        @(negedge clock);

        // Processor pass-through while idle (removed before the next edge).
        procWe = 1'b1; procReg = 5'd5; procData = 32'h1234;
        #1;
        checkOutput("idle_pass_we", wrEn, 1'b1);
        checkOutput("idle_pass_reg", wrReg, 5'd5);
        checkOutput("idle_pass_data", wrData, 32'h1234);
        procWe = 1'b0;
        #1;
        checkOutput("idle_we", wrEn, 1'b0);

        // Pass 1: clean default pass.
        applyStimulus(1'b1, 1'b0);
        checkOutput("p1_busy_fetch", busy, 1'b1);
        checkOutput("p1_tbl_addr", tblAddr, 5'd0);
        @(negedge clock);
        checkOutput("p1_first_we", wrEn, 1'b1);
        checkOutput("p1_first_reg", wrReg, 5'd1);
        checkOutput("p1_first_data", wrData, 32'h0000FFFF);
        waitDone(1'b0, doneAt);
        checkOutput("p1_done_latency", doneAt, DONE_LAT);
        checkOutput("p1_busy_done", busy, 1'b0);
        checkOutput("p1_we_done", wrEn, 1'b0);
        checkOutput("p1_pulses", wrCyc.size(), 15);
        checkOutput("p1_first_cycle", wrCyc.size() > 0 ? wrCyc[0] : -1, startCyc + 2);
        checkSpacing("p1_spacing");
        checkTable("p1");
        checkOutput("p1_collisions", collisions, 8'd0);
`ifdef READBACK_CHECK_EN
        checkOutput("p1_mismatches", mismatches, 8'd1);
        corruptR9 = 1'b0;
`endif

        // Pass 2: start from DONE, processor steals the third write slot.
        clearReq = 1'b1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("p2_done_cleared", done, 1'b0);
        repeat (17) @(negedge clock);
        procWe = 1'b1; procReg = 5'd7; procData = 32'd5;
        #1;
        checkOutput("p2_proc_we", wrEn, 1'b1);
        checkOutput("p2_proc_reg", wrReg, 5'd7);
        checkOutput("p2_proc_data", wrData, 32'd5);
        @(negedge clock);
        procWe = 1'b0;
        #1;
        checkOutput("p2_retry_we", wrEn, 1'b1);
        checkOutput("p2_retry_reg", wrReg, 5'd3);
        checkOutput("p2_retry_data", wrData, 32'h7FFFFFFF);
        checkOutput("p2_r7_proc", regs[7], 32'd5);
        checkOutput("p2_collisions", collisions, 8'd1);
        waitDone(1'b0, doneAt);
        checkOutput("p2_done_latency", doneAt, DONE_LAT + 1);
        checkOutput("p2_pulses", wrCyc.size(), 16);
        checkOutput("p2_proc_cycle", wrCyc.size() > 3 ? wrCyc[2] : -1, startCyc + 18);
        checkOutput("p2_seed3_cycle", wrCyc.size() > 3 ? wrCyc[3] : -1, startCyc + 19);
        checkOutput("p2_seed3_reg", wrRegLog.size() > 3 ? wrRegLog[3] : 5'd0, 5'd3);
        checkOutput("p2_seed4_cycle", wrCyc.size() > 4 ? wrCyc[4] : -1, startCyc + 27);
        checkTable("p2");
        checkOutput("p2_collisions_end", collisions, 8'd1);

        // Pass 3: reset in the WAIT after the fifth write.
        clearReq = 1'b1;
        applyStimulus(1'b1, 1'b0);
        repeat (35) @(negedge clock);
        ctrlReset = 1'b0;
        @(negedge clock);
        checkOutput("p3_busy", busy, 1'b0);
        checkOutput("p3_we", wrEn, 1'b0);
        checkOutput("p3_done", done, 1'b0);
        checkOutput("p3_tbl_addr", tblAddr, 5'd0);
        checkOutput("p3_collisions", collisions, 8'd0);
        checkOutput("p3_pulses", wrCyc.size(), 5);
        ctrlReset = 1'b1;
        repeat (10) @(negedge clock);
        checkOutput("p3_quiet", wrCyc.size(), 5);
`ifdef READBACK_CHECK_EN
        checkOutput("p3_mismatches", mismatches, 8'd0);
`endif

        // Pass 4: restart from r1 with start pulses arriving in WAIT, FETCH and WRITE.
        clearReq = 1'b1;
        applyStimulus(1'b1, 1'b0);
        repeat (7) @(negedge clock);
        start = 1'b1;
        repeat (3) @(negedge clock);
        start = 1'b0;
        waitDone(1'b0, doneAt);
        checkOutput("p4_done_latency", doneAt, DONE_LAT);
        checkOutput("p4_pulses", wrCyc.size(), 15);
        checkOutput("p4_first_reg", wrRegLog.size() > 0 ? wrRegLog[0] : 5'd0, 5'd1);
        checkOutput("p4_last_reg", wrRegLog.size() > 0 ? wrRegLog[wrRegLog.size()-1] : 5'd0, 5'd15);
        checkSpacing("p4_spacing");
        checkTable("p4");
`ifdef READBACK_CHECK_EN
        checkOutput("p4_mismatches", mismatches, 8'd0);
`endif

        // Pass 5: wrap-around instance skips r0.
        clearReq = 1'b1;
        applyStimulus(1'b0, 1'b1);
        waitDone(1'b1, doneAt);
        checkOutput("w_done_latency", doneAt, DONE_LAT2);
        checkOutput("w_pulses", pulses2, 3);
        checkOutput("w_r30", regs2[30], 32'hA5A50000);
        checkOutput("w_r31", regs2[31], 32'hA5A50001);
        checkOutput("w_r1", regs2[1], 32'hA5A50003);
        checkOutput("w_r2", regs2[2], 32'hDEAD0002);
        checkOutput("w_busy", busy2, 1'b0);
        checkOutput("w_collisions", collisions2, 8'd0);
`ifdef READBACK_CHECK_EN
        checkOutput("w_mismatches", mismatches2, 8'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
